multicycle_controller: RTL

Moore/Mealy FSM that sequences the shared single-ALU, single-memory MIPS datapath over multiple clock cycles. It replaces the one-cycle `Control` decode. Each cycle it drives every mux select and write enable of the PC, instruction register, register file, ALU and unified memory. It stalls on a memory ready handshake and counts retired instructions. It sits between the instruction register (opcode/funct) and the datapath muxes.

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/multicycle_controller_alu_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU and mux select encodings, and the controller state enum.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
   localparam logic [1:0] PCSRC_JUMP      = 2'b10;

   localparam logic [1:0] SRCB_REGB   = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   typedef enum logic [3:0] {
      S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTE, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the controller's ALU operation class plus the R-type funct field to
// the 3-bit ALU control code, and flags funct codes the ALU cannot execute.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       funct_valid
);

   logic [2:0] funct_ctl;

   always_comb begin
      funct_valid = 1'b1;
      funct_ctl   = ALU_ADD;
      case (funct)
         FN_ADD:  funct_ctl = ALU_ADD;
         FN_SUB:  funct_ctl = ALU_SUB;
         FN_AND:  funct_ctl = ALU_AND;
         FN_OR:   funct_ctl = ALU_OR;
         FN_SLT:  funct_ctl = ALU_SLT;
         default: funct_valid = 1'b0;
      endcase

      case (alu_op)
         ALUOP_SUB:   alu_control = ALU_SUB;
         ALUOP_FUNCT: alu_control = funct_ctl;
         default:     alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: sequences the shared ALU/memory datapath, stalls
// on memReady, traps on unsupported instructions and counts retired ones.
module multicycle_controller
   import mips_pkg::*;
#(
   parameter int RETIRED_W = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [5:0]           opcode,
   input  logic [5:0]           funct,
   input  logic                 zero,
   input  logic                 memReady,
   output logic                 memReq,
   output logic                 iOrD,
   output logic                 irWrite,
   output logic                 memWrite,
   output logic                 pcWrite,
   output logic [1:0]           pcSrc,
   output logic                 aluSrcA,
   output logic [1:0]           aluSrcB,
   output logic [2:0]           aluControl,
   output logic                 regDst,
   output logic                 memToReg,
   output logic                 regWrite,
   output logic                 illegal,
   output logic [RETIRED_W-1:0] retired
);

   state_t     state, state_nxt;
   logic [1:0] alu_op_nxt;
   logic [2:0] alu_ctl_nxt;
   logic       funct_ok;
   logic       in_fetch, in_branch, in_jump;
   logic       retire;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op_nxt),
      .funct       (funct),
      .alu_control (alu_ctl_nxt),
      .funct_valid (funct_ok)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_START:    state_nxt = S_FETCH;
         S_FETCH:    state_nxt = memReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = funct_ok ? S_EXECUTE : S_TRAP;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_J:         state_nxt = S_JUMP;
               default:      state_nxt = S_TRAP;
            endcase
         end
         S_MEMADR:   state_nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_nxt = memReady ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: state_nxt = memReady ? S_FETCH : S_MEMWRITE;
         S_EXECUTE:  state_nxt = S_ALUWB;
         S_ADDIEX:   state_nxt = S_ADDIWB;
         S_TRAP:     state_nxt = S_TRAP;
         default:    state_nxt = S_FETCH;
      endcase

      alu_op_nxt = ALUOP_ADD;
      if (state_nxt == S_EXECUTE)
         alu_op_nxt = ALUOP_FUNCT;
      else if (state_nxt == S_BRANCH)
         alu_op_nxt = ALUOP_SUB;

      retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_ADDIWB) ||
               (state == S_BRANCH) || (state == S_JUMP) ||
               ((state == S_MEMWRITE) && memReady);
   end

   // Outputs are registered against the state being entered; only the
   // memReady-qualified fetch loads and the zero-qualified branch stay Mealy.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_START;
         memReq     <= 1'b0;
         iOrD       <= 1'b0;
         memWrite   <= 1'b0;
         pcSrc      <= 2'b00;
         aluSrcA    <= 1'b0;
         aluSrcB    <= 2'b00;
         aluControl <= 3'b000;
         regDst     <= 1'b0;
         memToReg   <= 1'b0;
         regWrite   <= 1'b0;
         in_fetch   <= 1'b0;
         in_branch  <= 1'b0;
         in_jump    <= 1'b0;
         illegal    <= 1'b0;
         retired    <= '0;
      end else begin
         state      <= state_nxt;
         memReq     <= 1'b0;
         iOrD       <= 1'b0;
         memWrite   <= 1'b0;
         pcSrc      <= PCSRC_ALURESULT;
         aluSrcA    <= 1'b0;
         aluSrcB    <= SRCB_REGB;
         aluControl <= 3'b000;
         regDst     <= 1'b0;
         memToReg   <= 1'b0;
         regWrite   <= 1'b0;
         in_fetch   <= 1'b0;
         in_branch  <= 1'b0;
         in_jump    <= 1'b0;
         case (state_nxt)
            S_FETCH: begin
               memReq     <= 1'b1;
               aluSrcB    <= SRCB_FOUR;
               aluControl <= alu_ctl_nxt;
               in_fetch   <= 1'b1;
            end
            S_DECODE: begin
               aluSrcB    <= SRCB_IMM_SH;
               aluControl <= alu_ctl_nxt;
            end
            S_MEMADR, S_ADDIEX: begin
               aluSrcA    <= 1'b1;
               aluSrcB    <= SRCB_IMM;
               aluControl <= alu_ctl_nxt;
            end
            S_MEMREAD: begin
               memReq <= 1'b1;
               iOrD   <= 1'b1;
            end
            S_MEMWRITE: begin
               memReq   <= 1'b1;
               iOrD     <= 1'b1;
               memWrite <= 1'b1;
            end
            S_MEMWB: begin
               regWrite <= 1'b1;
               memToReg <= 1'b1;
            end
            S_EXECUTE, S_BRANCH: begin
               aluSrcA    <= 1'b1;
               aluControl <= alu_ctl_nxt;
               in_branch  <= (state_nxt == S_BRANCH);
               pcSrc      <= (state_nxt == S_BRANCH) ? PCSRC_ALUOUT : PCSRC_ALURESULT;
            end
            S_ALUWB: begin
               regWrite <= 1'b1;
               regDst   <= 1'b1;
            end
            S_ADDIWB: regWrite <= 1'b1;
            S_JUMP: begin
               pcSrc   <= PCSRC_JUMP;
               in_jump <= 1'b1;
            end
            default: ;
         endcase
         illegal <= illegal | (state_nxt == S_TRAP);
         if (retire)
            retired <= retired + RETIRED_W'(1);
      end
   end

   assign irWrite = in_fetch & memReady;
   assign pcWrite = (in_fetch & memReady) | (in_branch & zero) | in_jump;

endmodule
